mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//  Initiator/sequencer for the MAC datapath: computes result[r] = sum_k A[r][k]*B[k] (matrix-vector).
//  Reads A and B from external 1-cycle-latency synchronous RAMs and drives the MAC operands and
//  macc_clear. Captures the MAC accumulator once per row and writes it to a result RAM.
//  Sits between the operand memories and the MAC; start/busy/done face the top-level control.
// PARAMETERS
//  DW      8   operand width (MAC inA/inB)
//  ACC_W   19  accumulator width (MAC out)
//  N       8   elements per row (dot-product length), N >= 1
//  M       8   number of rows, M >= 1
//  AW_A    6   A address width, 2**AW_A >= M*N
//  AW_B    3   B address width, 2**AW_B >= N
//  AW_R    3   result address width, 2**AW_R >= M
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      1-cycle request; accepted only in IDLE
//  busy       out  1      high while a job runs
//  done       out  1      1-cycle pulse after final result write
//  a_addr     out  AW_A   A RAM read address (row-major: r*N+k)
//  a_rdata    in   DW     A RAM data, valid 1 cycle after a_addr
//  b_addr     out  AW_B   B RAM read address (k)
//  b_rdata    in   DW     B RAM data, valid 1 cycle after b_addr
//  mac_a      out  DW     to MAC inA
//  mac_b      out  DW     to MAC inB
//  macc_clear out  1      to MAC macc_clear (MAC out <= 0 at next edge)
//  mac_out    in   ACC_W  from MAC out (registered accumulator)
//  res_we     out  1      result RAM write enable
//  res_addr   out  AW_R   result RAM address (row r)
//  res_wdata  out  ACC_W  result RAM write data (= mac_out)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; busy=0, done=0, res_we=0, macc_clear=1, mac_a=mac_b=0,
//   all addresses 0, row/k counters 0. Reset mid-job aborts; no further res_we; no done.
//  States: IDLE, CLEAR, FEED, DRAIN, WRITE.
//   IDLE : macc_clear=1. start=1 -> CLEAR, row=0. start ignored in any other state.
//   CLEAR: 1 cycle, macc_clear=1 -> MAC out=0 at edge. -> FEED, k=0.
//   FEED : N cycles, macc_clear=0; a_addr=row*N+k, b_addr=k; k++. k==N-1 -> DRAIN.
//   DRAIN: 1 cycle; last operand pair at MAC inputs, summed at this edge. -> WRITE.
//   WRITE: 1 cycle; res_we=1, res_addr=row, res_wdata=mac_out (final row sum).
//          row<M-1 -> CLEAR, row++; else -> IDLE with done=1 on the next cycle.
//  Operand gating: rd_valid register = (state==FEED) delayed 1 cycle. mac_a = rd_valid ? a_rdata : 0,
//   mac_b = rd_valid ? b_rdata : 0 (combinational). MAC sees zero operands in every non-data cycle,
//   so its free-running accumulation adds 0.
//  busy=1 from first CLEAR through final WRITE. done rises the cycle after the final WRITE (state IDLE).
//  Latency: N+3 cycles/row; start accepted -> done = M*(N+3)+1 cycles.
//  start asserted in the done cycle is accepted (back-to-back jobs).
//  Width: sum wraps modulo 2**ACC_W in the MAC. No overflow when N*(2**DW-1)**2 < 2**ACC_W
//   (defaults: 520200 < 524288). No saturation.
//  res_we is high only in WRITE; exactly M writes per job, rows 0..M-1 in order.
// TESTING (bench: behavioural MAC + 1-cycle RAM models, defaults N=M=8)
//  1 A=all 1, B=all 1, start -> 8 writes of 8 to rows 0..7; done 89 cycles after start.
//  2 A[r][k]=k+1, B[k]=k+2 -> every row writes 240; res_addr steps 0..7.
//  3 A=B=255 everywhere -> every row writes 520200 (no wrap).
//  4 start pulsed while busy at row 2 -> ignored; results and done timing same as test 1.
//  5 rst_n=0 one cycle during row 3 FEED -> next cycle busy=0, macc_clear=1, res_we=0;
//    new start gives correct full results.
//  6 start in the done cycle -> second job begins next cycle (CLEAR); results correct.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Sequencer for a matrix-vector multiply on an external MAC:
//   result[r] = sum_k A[r][k] * B[k],  r = 0..M-1, k = 0..N-1
// Reads A (row-major, r*N+k) and B (k) from 1-cycle-latency synchronous RAMs.
// Feeds the operand pairs to the MAC and clears the accumulator before each row.
// Writes the finished accumulator of each row to a result RAM.
//
// Ports
//   clk, rst_n            clock and synchronous active-low reset
//   start / busy / done   job handshake (start accepted only when idle, done = 1-cycle pulse)
//   a_addr / a_rdata      A RAM read port
//   b_addr / b_rdata      B RAM read port
//   mac_a, mac_b          MAC operands (zero in every non-data cycle)
//   macc_clear            MAC accumulator clear
//   mac_out               MAC registered accumulator
//   res_we / res_addr / res_wdata   result RAM write port
//
// Row schedule (N+3 cycles): CLEAR, N x FEED, DRAIN, WRITE.
module mac_seq_ctrl #(
  parameter int DW    = 8,
  parameter int ACC_W = 19,
  parameter int N     = 8,
  parameter int M     = 8,
  parameter int AW_A  = 6,
  parameter int AW_B  = 3,
  parameter int AW_R  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW_A-1:0]  a_addr,
  input  logic [DW-1:0]    a_rdata,
  output logic [AW_B-1:0]  b_addr,
  input  logic [DW-1:0]    b_rdata,
  output logic [DW-1:0]    mac_a,
  output logic [DW-1:0]    mac_b,
  output logic             macc_clear,
  input  logic [ACC_W-1:0] mac_out,
  output logic             res_we,
  output logic [AW_R-1:0]  res_addr,
  output logic [ACC_W-1:0] res_wdata
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  localparam logic [AW_B-1:0] K_LAST   = AW_B'(N - 1);
  localparam logic [AW_R-1:0] ROW_LAST = AW_R'(M - 1);

  state_t            state_r;
  state_t            next_s;
  logic [AW_R-1:0]   row_r;
  logic [AW_B-1:0]   k_r;
  // Running A address; because A is row-major and rows are visited in order,
  // it always equals row*N+k without needing a multiplier.
  logic [AW_A-1:0]   a_ptr_r;
  logic              rd_valid_r;
  logic              done_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_s = ST_CLEAR;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_CLEAR: next_s = ST_FEED;
      ST_FEED: begin
        if (k_r == K_LAST) begin
          next_s = ST_DRAIN;
        end else begin
          next_s = ST_FEED;
        end
      end
      ST_DRAIN: next_s = ST_WRITE;
      ST_WRITE: begin
        if (row_r == ROW_LAST) begin
          next_s = ST_IDLE;
        end else begin
          next_s = ST_CLEAR;
        end
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // Row, element and A-address counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_r   <= '0;
      k_r     <= '0;
      a_ptr_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          row_r   <= '0;
          k_r     <= '0;
          a_ptr_r <= '0;
        end
        ST_CLEAR: begin
          k_r <= '0;
        end
        ST_FEED: begin
          k_r     <= k_r + AW_B'(1);
          a_ptr_r <= a_ptr_r + AW_A'(1);
        end
        ST_WRITE: begin
          if (row_r != ROW_LAST) begin
            row_r <= row_r + AW_R'(1);
          end else begin
            row_r <= row_r;
          end
        end
        default: begin
          row_r   <= row_r;
          k_r     <= k_r;
          a_ptr_r <= a_ptr_r;
        end
      endcase
    end
  end

  // RAM data returns one cycle after a FEED address, so operand validity
  // is FEED delayed by one cycle; done pulses the cycle after the last WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      rd_valid_r <= (state_r == ST_FEED);
      done_r     <= (state_r == ST_WRITE) && (row_r == ROW_LAST);
    end
  end

  // Moore output decode from the state register.
  always_comb begin
    busy       = 1'b0;
    macc_clear = 1'b0;
    a_addr     = '0;
    b_addr     = '0;
    res_we     = 1'b0;
    res_addr   = '0;
    case (state_r)
      ST_IDLE: begin
        macc_clear = 1'b1;
      end
      ST_CLEAR: begin
        busy       = 1'b1;
        macc_clear = 1'b1;
      end
      ST_FEED: begin
        busy   = 1'b1;
        a_addr = a_ptr_r;
        b_addr = k_r;
      end
      ST_DRAIN: begin
        busy = 1'b1;
      end
      ST_WRITE: begin
        busy     = 1'b1;
        res_we   = 1'b1;
        res_addr = row_r;
      end
      default: begin
        macc_clear = 1'b1;
      end
    endcase
  end

  // Zero operands outside data cycles so the free-running MAC adds nothing.
  assign mac_a     = rd_valid_r ? a_rdata : {DW{1'b0}};
  assign mac_b     = rd_valid_r ? b_rdata : {DW{1'b0}};
  assign res_wdata = mac_out;
  assign done      = done_r;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  localparam int DW      = 8;
  localparam int ACC_W   = 19;
  localparam int N       = 8;
  localparam int M       = 8;
  localparam int AW_A    = 6;
  localparam int AW_B    = 3;
  localparam int AW_R    = 3;
  localparam int ROW_CYC = N + 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic [AW_A-1:0]  a_addr;
  logic [DW-1:0]    a_rdata;
  logic [AW_B-1:0]  b_addr;
  logic [DW-1:0]    b_rdata;
  logic [DW-1:0]    mac_a;
  logic [DW-1:0]    mac_b;
  logic             macc_clear;
  logic [ACC_W-1:0] mac_out;
  logic             res_we;
  logic [AW_R-1:0]  res_addr;
  logic [ACC_W-1:0] res_wdata;

  logic [DW-1:0] a_mem [0:M*N-1];
  logic [DW-1:0] b_mem [0:N-1];

  int errors;
  int checks;
  int cyc;
  int wr_n;
  int wr_addr [0:63];
  longint wr_data [0:63];

  mac_seq_ctrl #(
    .DW(DW), .ACC_W(ACC_W), .N(N), .M(M), .AW_A(AW_A), .AW_B(AW_B), .AW_R(AW_R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .a_addr(a_addr), .a_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .macc_clear(macc_clear), .mac_out(mac_out),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand RAMs with one cycle read latency.
  always @(posedge clk) begin
    a_rdata <= a_mem[a_addr];
    b_rdata <= b_mem[b_addr];
  end

  // Behavioural MAC: clear or accumulate product, wrapping at ACC_W bits.
  always @(posedge clk) begin
    if (macc_clear) mac_out <= '0;
    else mac_out <= ACC_W'(32'(mac_a) * 32'(mac_b) + 32'(mac_out));
  end

  // Result RAM write log.
  always @(negedge clk) begin
    if (res_we && wr_n < 64) begin
      wr_addr[wr_n] = int'(res_addr);
      wr_data[wr_n] = longint'(res_wdata);
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_row(input int r);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(a_mem[r*N+k]) * longint'(b_mem[k]);
    return s % (longint'(1) << ACC_W);
  endfunction

  // mode 0: all ones, 1: A=k+1 B=k+2, 2: all 255, 3: random
  task automatic fill(input int mode);
    for (int r = 0; r < M; r++)
      for (int k = 0; k < N; k++)
        case (mode)
          0: a_mem[r*N+k] = 8'd1;
          1: a_mem[r*N+k] = 8'(k + 1);
          2: a_mem[r*N+k] = 8'd255;
          default: a_mem[r*N+k] = 8'($urandom_range(0, 255));
        endcase
    for (int k = 0; k < N; k++)
      case (mode)
        0: b_mem[k] = 8'd1;
        1: b_mem[k] = 8'(k + 2);
        2: b_mem[k] = 8'd255;
        default: b_mem[k] = 8'($urandom_range(0, 255));
      endcase
  endtask

  task automatic run_job(input string tag, input bit pre_started, input bit mid_start,
                         input bit chain_next);
    int s;
    bit got;
    wr_n = 0;
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
    end
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_clear_cycle"}, longint'({busy, macc_clear}), 64'd3);
    got = 1'b0;
    for (int i = 0; i < M*ROW_CYC + 20; i++) begin
      if (mid_start && (cyc - s) == 2*ROW_CYC + 4) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, longint'(got), 64'd1);
    chk({tag, "_latency"}, longint'(cyc - s), longint'(M*ROW_CYC + 1));
    chk({tag, "_busy_at_done"}, longint'(busy), 64'd0);
    chk({tag, "_writes"}, longint'(wr_n), longint'(M));
    for (int r = 0; r < M && r < wr_n; r++) begin
      chk($sformatf("%s_addr%0d", tag, r), longint'(wr_addr[r]), longint'(r));
      chk($sformatf("%s_data%0d", tag, r), wr_data[r], exp_row(r));
    end
    if (chain_next) start = 1'b1;
  endtask

  initial begin
    int s;
    bit bad;
    errors = 0;
    checks = 0;
    wr_n = 0;
    start = 1'b0;
    rst_n = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 64'd0);
    chk("rst_done", longint'(done), 64'd0);
    chk("rst_res_we", longint'(res_we), 64'd0);
    chk("rst_macc_clear", longint'(macc_clear), 64'd1);
    chk("rst_mac_ops", longint'({mac_a, mac_b}), 64'd0);
    chk("rst_addrs", longint'({a_addr, b_addr, res_addr}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all ones: rows of 8
    fill(0);
    run_job("ones", 1'b0, 1'b0, 1'b0);
    // arithmetic pattern: rows of 240
    fill(1);
    run_job("ramp", 1'b0, 1'b0, 1'b0);
    chk("ramp_row_value", exp_row(0), 64'd240);
    // maximum operands: 520200, no wrap
    fill(2);
    run_job("max", 1'b0, 1'b0, 1'b0);
    chk("max_row_value", exp_row(M-1), 64'd520200);
    // start pulse while busy is ignored
    fill(0);
    run_job("busy_start", 1'b0, 1'b1, 1'b0);

    // reset during row 3 FEED aborts the job
    fill(3);
    wr_n = 0;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    while ((cyc - s) < 3*ROW_CYC + 4) @(negedge clk);
    chk("abort_prior_writes", longint'(wr_n), 64'd3);
    chk("abort_in_feed", longint'({busy, macc_clear}), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", longint'(busy), 64'd0);
    chk("abort_macc_clear", longint'(macc_clear), 64'd1);
    chk("abort_res_we", longint'(res_we), 64'd0);
    chk("abort_mac_ops", longint'({mac_a, mac_b}), 64'd0);
    bad = 1'b0;
    wr_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || res_we) bad = 1'b1;
    end
    chk("abort_quiet", longint'(bad), 64'd0);
    chk("abort_no_writes", longint'(wr_n), 64'd0);
    run_job("after_abort", 1'b0, 1'b0, 1'b0);

    // back-to-back: start in done cycle
    fill(3);
    run_job("chain1", 1'b0, 1'b0, 1'b1);
    fill(3);
    run_job("chain2", 1'b1, 1'b0, 1'b0);

    // a few more random jobs
    for (int j = 0; j < 3; j++) begin
      fill(3);
      run_job($sformatf("rand%0d", j), 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
